aes_enc_iter_ctrl: RTL and testbench



---
 rtl/aes_enc_iter_ctrl_pkg.sv | 63 ++++++
 rtl/aes_enc_iter_ctrl_if.sv | 20 ++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_round.sv | 39 +++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_enc_iter_ctrl.sv | 90 +++++++++
 tb/tb_aes_enc_iter_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_enc_iter_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 encryption controller.
package aes_enc_iter_ctrl_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_RCON_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Round constant for the key schedule step that produces round key idx+1.
    function automatic logic [AES_RCON_W-1:0] aes_rcon(input logic [3:0] idx);
        logic [AES_RCON_W-1:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // S-box as inverse (b^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_enc_iter_ctrl_if.sv
// Block source/sink handshake bundle; the controller is the slave, the environment the master.
interface aes_enc_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key schedule step: derives the next round key from the current one.
module aes_key_step
    import aes_enc_iter_ctrl_pkg::*;
(
    input  logic [127:0]            key_in,
    input  logic [AES_RCON_W-1:0]   rcon,
    output logic [127:0]            key_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] w4, w5, w6, w7;

    assign w0  = key_in[127:96];
    assign w1  = key_in[95:64];
    assign w2  = key_in[63:32];
    assign w3  = key_in[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign t       = sub ^ {rcon, 24'h0};
    assign w4      = w0 ^ t;
    assign w5      = w4 ^ w1;
    assign w6      = w5 ^ w2;
    assign w7      = w6 ^ w3;
    assign key_out = {w4, w5, w6, w7};
endmodule

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
module aes_round
    import aes_enc_iter_ctrl_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_out
);
    logic [7:0] sub [16];
    logic [7:0] shf [16];
    logic [7:0] mix [16];

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(state_in[127-8*i -: 8]), .y(sub[i]));
    end

    // Byte i sits at row i%4, column i/4; rows rotate left by their row number, then columns mix.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
        shf       = '{default: 8'h00};
        mix       = '{default: 8'h00};
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[4*c+r] = sub[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[4*c+0] = gf_xtime(shf[4*c]) ^ gf_xtime(shf[4*c+1]) ^ shf[4*c+1] ^ shf[4*c+2] ^ shf[4*c+3];
            mix[4*c+1] = shf[4*c] ^ gf_xtime(shf[4*c+1]) ^ gf_xtime(shf[4*c+2]) ^ shf[4*c+2] ^ shf[4*c+3];
            mix[4*c+2] = shf[4*c] ^ shf[4*c+1] ^ gf_xtime(shf[4*c+2]) ^ gf_xtime(shf[4*c+3]) ^ shf[4*c+3];
            mix[4*c+3] = gf_xtime(shf[4*c]) ^ shf[4*c] ^ shf[4*c+1] ^ shf[4*c+2] ^ gf_xtime(shf[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127-8*i -: 8] = (final_round ? shf[i] : mix[i]) ^ round_key[127-8*i -: 8];
        end
    end
endmodule

// File: rtl/aes_sbox.sv
// Single AES S-box lookup, computed arithmetically.
module aes_sbox
    import aes_enc_iter_ctrl_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = sbox_calc(a);
endmodule

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys derived on the fly.
module aes_enc_iter_ctrl
    import aes_enc_iter_ctrl_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int RCON_W = AES_RCON_W
) (
    input  logic                clk,
    input  logic                rst,
    aes_enc_iter_ctrl_if.slave  bus,
    output logic                busy,
    output logic [3:0]          round_idx
);
    if (NR != 10 || RCON_W != 8) begin : g_bad_param
        $error("aes_enc_iter_ctrl supports only NR=10 and RCON_W=8");
    end

    localparam logic [3:0] LAST = 4'(NR);

    state_e              state, state_nx;
    logic [127:0]        state_q, key_q, key_nx, round_out;
    logic [3:0]          round_q;
    logic [RCON_W-1:0]   rcon;
    logic                last_round, in_ready, accept, handoff;

    assign last_round = (round_q == LAST);
    assign rcon       = aes_rcon(round_q - 4'd1);
    assign handoff    = (state == S_DONE) && bus.out_ready;
    assign in_ready   = (state == S_IDLE) || handoff;
    assign accept     = bus.in_valid && in_ready;

    aes_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (rcon),
        .key_out (key_nx)
    );

    aes_round u_round (
        .state_in    (state_q),
        .round_key   (key_nx),
        .final_round (last_round),
        .state_out   (round_out)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_block = state_q;
    assign busy          = (state == S_ROUND);
    assign round_idx     = round_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state: a hand-off with a waiting block goes straight back to ROUND.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_ROUND;
            S_ROUND: if (last_round) state_nx = S_DONE;
            S_DONE: begin
                if (accept)       state_nx = S_ROUND;
                else if (handoff) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Cipher state, current round key and round counter; inputs are captured only at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= 4'd0;
        end else if (accept) begin
            state_q <= bus.in_block ^ bus.in_key;
            key_q   <= bus.in_key;
            round_q <= 4'd1;
        end else if (state == S_ROUND) begin
            state_q <= round_out;
            key_q   <= key_nx;
            if (!last_round) round_q <= round_q + 4'd1;
        end else if (handoff) begin
            round_q <= 4'd0;
        end
    end
endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Self-checking bench for aes_enc_iter_ctrl: known-answer vectors plus a byte-array AES reference model.
module tb_aes_enc_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [3:0] round_idx;
    int         n_tests = 0;
    int         n_fail  = 0;

    aes_enc_iter_ctrl_if bus ();

    aes_enc_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K3 = 128'h0;
    localparam logic [127:0] P3 = 128'h0;
    localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] tbl;
        tbl = SBOX_TBL;
        return tbl[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Textbook AES-128: full key expansion up front, then 10 rounds on a 16-byte column-major array.
    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[c*4+rr] = t[((c+rr)%4)*4+rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
                    s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, busy, round_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required %b", {bus.in_ready, bus.out_valid, busy, round_idx}, 7'b1000000);
        end
        n_tests++;
        if (bus.out_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_out_block: got %h required 0", bus.out_block);
        end
    endtask

    // Single block with exact per-cycle latency; inputs and out_ready are scrambled while rounds run.
    task automatic test_vector(input string name, input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] exp);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_block = pt; bus.in_key = key; bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept_ready: got %b required 1", name, bus.in_ready);
        end
        @(posedge clk);
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_block  = rand128();
            bus.in_key    = rand128();
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if ({bus.out_valid, busy, round_idx, bus.in_ready} !== {1'b0, 1'b1, 4'(e + 1), 1'b0}) begin
                n_fail++;
                $display("FAIL %s_round_edge%0d: got %b required %b", name, e,
                         {bus.out_valid, busy, round_idx, bus.in_ready}, {1'b0, 1'b1, 4'(e + 1), 1'b0});
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, busy, round_idx} !== {1'b1, 1'b0, 4'd10}) begin
            n_fail++;
            $display("FAIL %s_done_flags: got %b required %b", name, {bus.out_valid, busy, round_idx}, 6'b101010);
        end
        n_tests++;
        if (bus.out_block !== exp) begin
            n_fail++;
            $display("FAIL %s_out_block: got %h required %h", name, bus.out_block, exp);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s_after_handoff: got %b required 010", name, {bus.out_valid, bus.in_ready, busy});
        end
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_block = P2; bus.in_key = K2; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        #1;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk); #1; w++;
        end
        n_tests++;
        if (w !== 10) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d required 10", w);
        end
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1; bus.in_block = rand128(); bus.in_key = rand128();
            #1;
            n_tests++;
            if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.out_block !== C2) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %b/%h required 10/%h", i, {bus.out_valid, bus.in_ready}, bus.out_block, C2);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_block = P1; bus.in_key = K1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, busy, round_idx} !== {1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL bp_reaccept: got %b required 010001", {bus.out_valid, busy, round_idx});
        end
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk); #1; w++;
        end
        n_tests++;
        if (w !== 10 || bus.out_block !== C1) begin
            n_fail++;
            $display("FAIL bp_second_result: got %0d/%h required 10/%h", w, bus.out_block, C1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] keys [6];
        logic [127:0] pts  [6];
        logic [127:0] exps [6];
        int sent = 0, got = 0, cyc = 0, last = 0;
        keys[0] = K1; pts[0] = P1; exps[0] = C1;
        keys[1] = K2; pts[1] = P2; exps[1] = C2;
        keys[2] = K3; pts[2] = P3; exps[2] = C3;
        for (int i = 3; i < 6; i++) begin
            keys[i] = rand128(); pts[i] = rand128(); exps[i] = aes_model(keys[i], pts[i]);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        while (got < 6 && cyc < 200) begin
            bus.in_valid = 1'(sent < 6);
            if (sent < 6) begin
                bus.in_block = pts[sent]; bus.in_key = keys[sent];
            end
            #1;
            if (bus.out_valid) begin
                n_tests++;
                if (bus.out_block !== exps[got]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got %h required %h", got, bus.out_block, exps[got]);
                end
                if (got > 0) begin
                    n_tests++;
                    if (cyc - last !== 11) begin
                        n_fail++;
                        $display("FAIL b2b_spacing%0d: got %0d required 11", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results required 6", got);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    // Random valid/ready gaps with random blocks; results checked in order against the model.
    task automatic test_random();
        logic [127:0] exp_q [$];
        logic [127:0] e;
        int sent = 0, got = 0, cyc = 0;
        @(negedge clk);
        while (got < 10 && cyc < 3000) begin
            bus.in_valid  = (sent < 10) && ($urandom_range(0, 2) != 0);
            bus.in_block  = rand128();
            bus.in_key    = rand128();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: got %h required no output", bus.out_block);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_block !== e) begin
                        n_fail++;
                        $display("FAIL rand_result%0d: got %h required %h", got, bus.out_block, e);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(aes_model(bus.in_key, bus.in_block));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (got !== 10) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d results required 10", got);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_round();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_block = P1; bus.in_key = K1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_tests++;
        if ({busy, round_idx} !== {1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL rst_mid_precond: got %b required 10101", {busy, round_idx});
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid, busy, round_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %b required 1000000", {bus.in_ready, bus.out_valid, busy, round_idx});
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_spurious%0d: got %b required 00", i, {bus.out_valid, busy});
            end
        end
        bus.out_ready = 1'b0;
        test_vector("post_reset_c1", K1, P1, C1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vector("fips_c1", K1, P1, C1);
        test_vector("fips_b", K2, P2, C2);
        test_vector("all_zero", K3, P3, C3);
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_round();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
